// File: rtl/mmap_initiator.sv
// mmap_initiator: serial mmap host initiator; frames a request as header/data bytes and collects read words.
// Ports: clk, rst_n (async active-low); req_* request handshake; wdata/wdata_valid/wdata_ready write words;
// rdata/rdata_valid read words; tx_data/new_tx_data/tx_busy to serial_tx; rx_data/new_rx_data from serial_rx;
// busy (not idle), err (response timeout pulse).
// Optional MMAP_INIT_RX_TIMEOUT_EN: aborts a read after RX_TIMEOUT idle cycles between response bytes.
module mmap_initiator #(
  parameter int CLK_FREQ   = 50000000,
  parameter int RX_TIMEOUT = CLK_FREQ / 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_inc,
  input  logic [5:0]  req_cmd,
  input  logic [15:0] req_count,
  input  logic [31:0] req_addr,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, HDR, WDATA, WSEND, RECV} state_t;
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] words_q, words_d, cnt_q, cnt_d;
  logic [7:0]  op_q, op_d, tx_data_q, tx_data_d;
  logic [31:0] addr_q, addr_d, sh_q, sh_d, rdata_q, rdata_d;
  logic        req_ready_q, req_ready_d, busy_q, busy_d, new_tx_q, new_tx_d;
  logic        wready_q, wready_d, rvalid_q, rvalid_d;
  logic [55:0] hdr;
  logic        tx_ok;
`ifdef MMAP_INIT_RX_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  assign err = err_q;
`else
  logic unused_rx_timeout;
  assign unused_rx_timeout = ^32'(RX_TIMEOUT);
  assign err = 1'b0;
`endif
  // Header bytes in wire order, byte 0 at the bottom.
  assign hdr   = {addr_q, cnt_q, op_q};
  // A strobe is never issued in the cycle right after another, which also covers serial_tx's busy latency.
  assign tx_ok = !tx_busy && !new_tx_q;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    sh_d      = sh_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
`ifdef MMAP_INIT_RX_TIMEOUT_EN
    tmo_d     = '0;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        op_d    = {req_write, req_inc, req_cmd};
        cnt_d   = req_count;
        addr_d  = req_addr;
        words_d = req_count;
        idx_d   = '0;
        state_d = HDR;
      end
      HDR: if (tx_ok) begin
        new_tx_d  = 1'b1;
        tx_data_d = hdr[{idx_q, 3'b000} +: 8];
        idx_d     = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
        if (idx_q == 3'd6) state_d = op_q[7] ? WDATA : RECV;
      end
      WDATA: if (wdata_valid) begin
        wready_d = 1'b1;
        sh_d     = wdata;
        state_d  = WSEND;
      end
      WSEND: if (tx_ok) begin
        new_tx_d  = 1'b1;
        tx_data_d = sh_q[{idx_q[1:0], 3'b000} +: 8];
        idx_d     = (idx_q == 3'd3) ? 3'd0 : idx_q + 3'd1;
        if (idx_q == 3'd3) begin
          state_d = (words_q == 16'd0) ? IDLE : WDATA;
          words_d = (words_q == 16'd0) ? words_q : words_q - 16'd1;
        end
      end
      RECV: if (new_rx_data) begin
        sh_d  = {rx_data, sh_q[31:8]};
        idx_d = (idx_q == 3'd3) ? 3'd0 : idx_q + 3'd1;
        if (idx_q == 3'd3) begin
          rdata_d  = {rx_data, sh_q[31:8]};
          rvalid_d = 1'b1;
          state_d  = (words_q == 16'd0) ? IDLE : RECV;
          words_d  = (words_q == 16'd0) ? words_q : words_q - 16'd1;
        end
      end else begin
`ifdef MMAP_INIT_RX_TIMEOUT_EN
        tmo_d = tmo_q + 32'd1;
        // Partial word is dropped; the remote decoder resynchronises on its own idle timeout.
        if (tmo_d == 32'(RX_TIMEOUT)) begin
          err_d   = 1'b1;
          idx_d   = '0;
          tmo_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      words_q     <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      sh_q        <= '0;
      rdata_q     <= '0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
      wready_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MMAP_INIT_RX_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      rdata_q     <= rdata_d;
      tx_data_q   <= tx_data_d;
      new_tx_q    <= new_tx_d;
      wready_q    <= wready_d;
      rvalid_q    <= rvalid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
`ifdef MMAP_INIT_RX_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign wdata_ready = wready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
endmodule

// File: tb/tb_mmap_initiator.sv
// tb_mmap_initiator: scoreboard bench for mmap_initiator; expected bytes/words queued by stimulus, checked by a monitor.
module tb_mmap_initiator;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_inc = 1'b0;
  logic [5:0]  req_cmd = '0;
  logic [15:0] req_count = '0;
  logic [31:0] req_addr = '0, wdata = '0;
  logic        wdata_valid = 1'b0, tx_busy = 1'b0, new_rx_data = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        req_ready, wdata_ready, rdata_valid, new_tx_data, busy, err;
  logic [31:0] rdata;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  mmap_initiator #(.CLK_FREQ(1000), .RX_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_inc(req_inc), .req_cmd(req_cmd), .req_count(req_count),
    .req_addr(req_addr), .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .rx_data(rx_data), .new_rx_data(new_rx_data), .busy(busy), .err(err)
  );

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  int n_cmp = 0, n_bad = 0, n_txb = 0, n_wr = 0, n_err = 0, exp_err = 0;
  logic prev_stb = 1'b0, prev_busy = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (new_tx_data) begin
        n_txb++;
        check("tx_spacing", {30'd0, prev_stb, prev_busy}, 32'd0);
        if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFFFFFF);
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      if (rdata_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", rdata, 32'hFFFFFFFF);
        else check("rd_word", rdata, exp_rd.pop_front());
      end
      if (wdata_ready) n_wr++;
      if (err) n_err++;
      prev_stb  = new_tx_data;
      prev_busy = tx_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit w, bit i, logic [5:0] c, logic [15:0] cnt, logic [31:0] a);
    int t = 0;
    exp_tx.push_back({w, i, c});
    exp_tx.push_back(cnt[7:0]);
    exp_tx.push_back(cnt[15:8]);
    for (int b = 0; b < 4; b++) exp_tx.push_back(a[8*b +: 8]);
    while (!req_ready && t < 1000) begin tick(); t++; end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_inc = i; req_cmd = c; req_count = cnt; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic put_word(logic [31:0] w, int delay);
    int t = 0;
    repeat (delay) tick();
    for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
    wdata = w;
    wdata_valid = 1'b1;
    do begin tick(); t++; end while (!wdata_ready && t < 2000);
    check("wdata_ready_seen", {31'd0, wdata_ready}, 32'd1);
    wdata_valid = 1'b0;
  endtask

  task automatic wait_hdr_sent();
    int t = 0;
    while (exp_tx.size() != 0 && t < 2000) begin tick(); t++; end
    check("hdr_sent", exp_tx.size(), 32'd0);
    tick();
  endtask

  task automatic rx_feed(logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_idle(string name);
    int t = 0;
    do begin tick(); t++; end while (!req_ready && t < 3000);
    tick();
    tick();
    check({name, "_idle"}, {30'd0, req_ready, busy}, 32'd2);
    check({name, "_txq_empty"}, exp_tx.size(), 32'd0);
    check({name, "_rdq_empty"}, exp_rd.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queues tx=%0d rd=%0d", exp_tx.size(), exp_rd.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pulses", {28'd0, new_tx_data, wdata_ready, rdata_valid, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single-word write: 85 00 00 00 10 00 00 EF BE AD DE
    base = n_wr;
    issue(1'b1, 1'b0, 6'h05, 16'd0, 32'h00001000);
    put_word(32'hDEADBEEF, 0);
    wait_idle("wr1");
    check("wr1_wready_count", n_wr - base, 32'd1);

    // two-word read
    exp_rd.push_back(32'h44332211);
    exp_rd.push_back(32'h88776655);
    issue(1'b0, 1'b0, 6'h02, 16'd1, 32'h00000004);
    wait_hdr_sent();
    for (int b = 1; b <= 8; b++) rx_feed(8'(b * 17));
    wait_idle("rd2");
    check("rd2_rdata_hold", rdata, 32'h88776655);

    // tx_busy held after the third header byte
    base = n_txb;
    issue(1'b1, 1'b1, 6'h07, 16'd0, 32'h12345678);
    c0 = 0;
    while (n_txb < base + 3 && c0 < 500) begin tick(); c0++; end
    check("stall_reached", n_txb - base, 32'd3);
    tx_busy = 1'b1;
    c0 = n_txb;
    repeat (100) tick();
    check("stall_no_strobe", n_txb, c0);
    tx_busy = 1'b0;
    put_word(32'hCAFEF00D, 0);
    wait_idle("stall");

    // three-word write with the second word withheld
    base = n_wr;
    issue(1'b1, 1'b1, 6'h3F, 16'd2, 32'h80000000);
    put_word(32'h11111111, 0);
    put_word(32'hA5A5C3C3, 50);
    put_word(32'h01020304, 0);
    wait_idle("wr3");
    check("wr3_wready_count", n_wr - base, 32'd3);

    // reset in the middle of a read response
    issue(1'b0, 1'b0, 6'h01, 16'd0, 32'h00000008);
    wait_hdr_sent();
    rx_feed(8'hAA);
    rx_feed(8'hBB);
    rst_n = 1'b0;
    #2;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_rd.push_back(32'h04030201);
    issue(1'b0, 1'b1, 6'h03, 16'd0, 32'h00000020);
    wait_hdr_sent();
    for (int b = 1; b <= 4; b++) rx_feed(8'(b));
    wait_idle("post_rst");
    check("post_rst_rdata", rdata, 32'h04030201);

`ifdef MMAP_INIT_RX_TIMEOUT_EN
    issue(1'b0, 1'b0, 6'h02, 16'd0, 32'h00000040);
    wait_hdr_sent();
    rx_feed(8'h10);
    rx_feed(8'h20);
    rx_data = 8'h30;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
    c0 = 0;
    while (!err && c0 < 500) begin tick(); c0++; end
    check("timeout_latency", c0, 32'd64);
    exp_err = 1;
    wait_idle("timeout");
`endif

    check("err_pulses", n_err, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
